// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic array front end.
// Feeder FSM encoding and lane slicing live here.
package sys_array_pkg;

   localparam int MAX_LANES = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feeder_state_t;

   typedef logic [MAX_LANES-1:0] lane_mask_t;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sys_skew_line.sv
// One lane of the input skew: DEPTH stages of {valid, data}.
// The whole line holds while hold is high.
module sys_skew_line #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [DATA_WIDTH:0] stage [DEPTH];

   // shift {valid, data} one stage per non-held cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (!hold) begin
         stage[0] <= {in_valid, in_data};
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign {out_valid, out_data} = stage[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// Diagonal-wavefront input skew for the systolic array row.
// Optional SYS_FEEDER_CNT_EN adds the vec_count output.
module sys_array_feeder
   import sys_array_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_H    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ARRAY_H*DATA_WIDTH-1:0] in_data,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic                          stall,
   output logic [ARRAY_H*DATA_WIDTH-1:0] out_data,
   output logic [ARRAY_H-1:0]            out_valid,
   output logic                          busy,
`ifdef SYS_FEEDER_CNT_EN
   output logic [15:0]                   vec_count,
`endif
   output logic                          done
);

   localparam int CNT_W = $clog2(ARRAY_H);

   feeder_state_t    state;
   logic [CNT_W-1:0] drain_cnt;
   logic             accept;
   logic             finish;

   assign in_ready = (state == STREAM) && !stall;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);
   assign finish   = (state == DRAIN) && (drain_cnt == '0) && !stall;

   // transaction sequencing: idle -> stream -> drain -> idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= '0;
      end else if (!stall) begin
         unique case (state)
            IDLE: begin
               if (start) state <= STREAM;
            end
            STREAM: begin
               if (accept && in_last) begin
                  state     <= DRAIN;
                  drain_cnt <= CNT_W'(ARRAY_H - 1);
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= IDLE;
               else drain_cnt <= drain_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // done is a single-cycle pulse; it drops even while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) done <= 1'b0;
      else       done <= finish;
   end

`ifdef SYS_FEEDER_CNT_EN
   // accepted-vector count, cleared by an accepted start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vec_count <= '0;
      end else if (!stall) begin
         if (state == IDLE && start)
            vec_count <= '0;
         else if (accept && vec_count != 16'hFFFF)
            vec_count <= vec_count + 16'd1;
      end
   end
`endif

   // lane i gets i+1 stages so it trails lane 0 by i cycles
   for (genvar i = 0; i < ARRAY_H; i++) begin : g_lane
      localparam int LO = lane_lo(i, DATA_WIDTH);
      logic [DATA_WIDTH-1:0] lane_in;

      assign lane_in = accept ? in_data[LO +: DATA_WIDTH] : '0;

      sys_skew_line #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (i + 1)
      ) u_line (
         .clk       (clk),
         .reset     (reset),
         .hold      (stall),
         .in_valid  (accept),
         .in_data   (lane_in),
         .out_valid (out_valid[i]),
         .out_data  (out_data[LO +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder with a history-based model.
// Build with SYS_FEEDER_CNT_EN defined to also check vec_count.
module tb_sys_array_feeder;

   localparam int DW = 8;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [H*DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic          stall = 1'b0;
   logic [H*DW-1:0] out_data;
   logic [H-1:0]  out_valid;
   logic          busy;
   logic          done;
`ifdef SYS_FEEDER_CNT_EN
   logic [15:0]   vec_count;
`endif

   int n_vec  = 0;
   int n_miss = 0;
   bit checking = 1'b0;

   sys_array_feeder #(.DATA_WIDTH(DW), .ARRAY_H(H)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .stall     (stall),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
`ifdef SYS_FEEDER_CNT_EN
      .vec_count (vec_count),
`endif
      .done      (done)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // model: every non-stalled edge pushes one entry into a history;
   // lane i after t pushes shows entry t-i, done fires H pushes
   // after the push of the last vector
   int            t = 0;
   bit            hist_v [0:4095];
   logic [H*DW-1:0] hist_d [0:4095];
   bit            m_active = 0;
   bit            m_acc = 0;
   int            done_at = -1;
   bit            m_done = 0;
   wire           m_accept = m_acc && in_valid;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t        <= 0;
         m_active <= 0;
         m_acc    <= 0;
         done_at  <= -1;
         m_done   <= 0;
      end else begin
         m_done <= !stall && (t + 1 == done_at);
         if (!stall) begin
            t <= t + 1;
            hist_v[t+1] <= m_accept;
            hist_d[t+1] <= m_accept ? in_data : '0;
            if (!m_active) begin
               if (start) begin
                  m_active <= 1;
                  m_acc    <= 1;
               end
            end else if (m_accept && in_last) begin
               m_acc   <= 0;
               done_at <= t + 1 + H;
            end
            if (t + 1 == done_at) begin
               m_active <= 0;
               done_at  <= -1;
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      logic [H*DW-1:0] ed;
      logic [H-1:0]    ev;
      if (checking) begin
         ed = '0;
         ev = '0;
         for (int i = 0; i < H; i++) begin
            if (t - i >= 1) begin
               ev[i] = hist_v[t-i];
               ed[i*DW +: DW] = hist_d[t-i][i*DW +: DW];
            end
         end
         chk("out_data", 64'(out_data), 64'(ed));
         chk("out_valid", 64'(out_valid), 64'(ev));
         chk("done", 64'(done), 64'(m_done));
         chk("busy", 64'(busy), 64'(m_active));
         chk("in_ready", 64'(in_ready), 64'(m_acc && !stall));
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [H*DW-1:0] d, input logic l);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic begin_txn();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // n0 edges already elapsed since the last accept (inclusive)
   task automatic wait_done(input int n0, input int expn,
                            input string nm);
      int n = n0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk(nm, 64'(n), 64'(expn));
   endtask

   initial begin
      // 1: reset mid-clock, then start
      #3 reset = 1'b1;
      checking = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      step();
      start = 1'b1;
      in_valid = 1'b1;
      in_data = 32'hDEADBEEF;
      step();
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_ready", 64'(in_ready), 64'd1);
      chk("start_noacc", 64'(out_valid), 64'd0);

      // 2: single vector {1,2,3,4}
      send(32'h04030201, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) begin
            chk("s2_lane", 64'(out_data[(k-1)*DW +: DW]), 64'(k));
            chk("s2_valid", 64'(out_valid), 64'(4'b0001 << (k - 1)));
         end else begin
            chk("s2_valid_end", 64'(out_valid), 64'd0);
         end
         chk("s2_done", 64'(done), 64'(k == 5));
         if (k < 5) step();
      end
      chk("s2_busy_end", 64'(busy), 64'd0);
      step();
      chk("s2_done_pulse", 64'(done), 64'd0);

      // 3: three back-to-back vectors
      begin_txn();
      send(32'h01010101, 1'b0);
      send(32'h02020202, 1'b0);
      chk("s3_lane0", 64'(out_data[7:0]), 64'd2);
      chk("s3_lane1", 64'(out_data[15:8]), 64'd1);
      send(32'h03030303, 1'b1);
      wait_done(1, 5, "s3_done_lat");
`ifdef SYS_FEEDER_CNT_EN
      chk("s3_count", 64'(vec_count), 64'd3);
`endif

      // 4: bubble between two vectors
      begin_txn();
      send(32'h08070605, 1'b0);
      step();
      send(32'h0C0B0A09, 1'b1);
      wait_done(1, 5, "s4_done_lat");

      // 5: stall for two cycles during drain
      begin_txn();
      send(32'h44332211, 1'b1);
      step();
      stall = 1'b1;
      #1;
      chk("s5_ready", 64'(in_ready), 64'd0);
      step();
      step();
      stall = 1'b0;
      wait_done(4, 7, "s5_done_lat");
      stall = 1'b1;
      step();
      chk("s5_done_drop", 64'(done), 64'd0);
      stall = 1'b0;
      step();

      // 6: reset while lanes 2 and 3 still hold data
      begin_txn();
      send(32'h0F0E0D0C, 1'b1);
      step();
      step();
      chk("s6_pre", 64'(out_valid), 64'b0100);
      reset = 1'b1;
      #1;
      chk("s6_valid", 64'(out_valid), 64'd0);
      chk("s6_data", 64'(out_data), 64'd0);
      chk("s6_busy", 64'(busy), 64'd0);
`ifdef SYS_FEEDER_CNT_EN
      chk("s6_count", 64'(vec_count), 64'd0);
`endif
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("s6_nodone", 64'(done), 64'd0);
      end
      begin_txn();
      send(32'h04030201, 1'b1);
      chk("s6_again", 64'(out_data[7:0]), 64'd1);
      wait_done(1, 5, "s6_done_lat");
      step();
      step();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
